// File: rtl/mac_accum_engine_pkg.sv
// ============================================================================
// Module      : mac_accum_package
// Description : Shared types and default widths for the MAC accumulate engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_accum_package;

    localparam int unsigned MAC_DATA_WIDTH = 32;
    localparam int unsigned MAC_ACC_WIDTH  = 64;
    localparam int unsigned MAC_CNT_WIDTH  = 16;

    typedef struct packed {
        logic                     start;
        logic [MAC_CNT_WIDTH-1:0] len;
        logic [MAC_CNT_WIDTH-1:0] nb_out;
        logic [5:0]               shift;
    } ctrl_engine_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [MAC_CNT_WIDTH-1:0] acc_cnt;
        logic [MAC_CNT_WIDTH-1:0] out_cnt;
    } flags_engine_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } mac_accum_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : Valid/ready data stream with byte strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

`default_nettype wire

// File: rtl/mac_accum_engine_datapath.sv
// ============================================================================
// Module      : mac_accum_datapath
// Description : Product register, accumulator and shift/reduce of the result.
//               Optional macro MAC_ACCUM_SAT_EN selects saturation over wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accum_datapath #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_acc_clr,
    input  logic                  i_res_load,
    input  logic [5:0]            i_shift,
    output logic                  o_acc_en,
    output logic [DATA_WIDTH-1:0] o_res
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic                           r_pvalid;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_shifted;
    logic        [DATA_WIDTH-1:0]   w_res;
    logic        [DATA_WIDTH-1:0]   r_res;

    assign w_prod     = $signed(i_a) * $signed(i_b);
    assign w_prod_ext = ACC_WIDTH'(r_prod);
    // Oversized shift amounts naturally collapse to all sign bits.
    assign w_shifted  = r_acc >>> i_shift;
    assign o_acc_en   = r_pvalid & i_en;
    assign o_res      = r_res;

`ifdef MAC_ACCUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MAX =
        (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MIN = ~C_SAT_MAX;

    always_comb begin
        w_res = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > C_SAT_MAX) begin
            w_res = C_SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < C_SAT_MIN) begin
            w_res = C_SAT_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        w_res = w_shifted[DATA_WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod   <= '0;
            r_pvalid <= 1'b0;
            r_acc    <= '0;
            r_res    <= '0;
        end else if (i_en) begin
            r_pvalid <= i_in_valid;
            if (i_in_valid) begin
                r_prod <= w_prod;
            end
            if (i_acc_clr) begin
                r_acc <= '0;
            end else if (r_pvalid) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (i_res_load) begin
                r_res <= w_res;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_accum_engine.sv
// ============================================================================
// Module      : mac_accum_engine
// Description : Signed multiply-accumulate stage: LEN products per result,
//               NB_OUT results per job. Macro MAC_ACCUM_SAT_EN enables saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accum_engine
    import mac_accum_package::*;
#(
    parameter int unsigned DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = MAC_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH  = MAC_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   clear_i,
    hwpe_stream_intf_stream.sink   a_i,
    hwpe_stream_intf_stream.sink   b_i,
    hwpe_stream_intf_stream.source c_o,
    input  ctrl_engine_t           ctrl_i,
    output flags_engine_t          flags_o
);

    mac_accum_state_t      r_state;
    mac_accum_state_t      w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_nb_out;
    logic [5:0]            r_shift;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_acc_cnt;
    logic [CNT_WIDTH-1:0]  r_out_cnt;
    logic                  w_clr;
    logic                  w_start_ok;
    logic                  w_in_hs;
    logic                  w_last_issue;
    logic                  w_acc_en;
    logic                  w_acc_done;
    logic                  w_out_hs;
    logic                  w_more_out;
    logic [DATA_WIDTH-1:0] w_res;

    assign w_clr        = ~rst_ni | clear_i;
    assign w_start_ok   = (ctrl_i.len != '0) && (ctrl_i.nb_out != '0);
    // Joint-valid pop: neither stream is ever consumed alone.
    assign w_in_hs      = (r_state == ST_RUN) & a_i.valid & b_i.valid & enable_i
                          & (r_issued < r_len);
    assign w_last_issue = w_in_hs & ((r_issued + CNT_WIDTH'(1)) == r_len);
    assign w_acc_done   = (r_state == ST_DRAIN) & (r_acc_cnt == r_len) & enable_i;
    assign w_out_hs     = (r_state == ST_EMIT) & c_o.ready & enable_i;
    assign w_more_out   = (r_out_cnt + CNT_WIDTH'(1)) < r_nb_out;

    assign a_i.ready = w_in_hs;
    assign b_i.ready = w_in_hs;
    assign c_o.valid = (r_state == ST_EMIT);
    assign c_o.data  = w_res;
    assign c_o.strb  = '1;

    mac_accum_datapath #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_datapath (
        .clk        (clk_i),
        .rst        (w_clr),
        .i_en       (enable_i),
        .i_in_valid (w_in_hs),
        .i_a        (a_i.data),
        .i_b        (b_i.data),
        .i_acc_clr  (w_out_hs),
        .i_res_load (w_acc_done),
        .i_shift    (r_shift),
        .o_acc_en   (w_acc_en),
        .o_res      (w_res)
    );

    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_state <= ST_IDLE;
        end else if (enable_i) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_i.start) begin
                    w_state_nxt = w_start_ok ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_acc_done) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_out_hs) begin
                    w_state_nxt = w_more_out ? ST_RUN : ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_len     <= '0;
            r_nb_out  <= '0;
            r_shift   <= '0;
            r_issued  <= '0;
            r_acc_cnt <= '0;
            r_out_cnt <= '0;
        end else if (enable_i) begin
            if ((r_state == ST_IDLE) && ctrl_i.start) begin
                r_len     <= ctrl_i.len;
                r_nb_out  <= ctrl_i.nb_out;
                r_shift   <= ctrl_i.shift;
                r_issued  <= '0;
                r_acc_cnt <= '0;
                r_out_cnt <= '0;
            end
            if (w_in_hs) begin
                r_issued <= r_issued + CNT_WIDTH'(1);
            end
            if (w_acc_en) begin
                r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
            end
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CNT_WIDTH'(1);
                r_acc_cnt <= '0;
                r_issued  <= '0;
            end
        end
    end

    always_comb begin
        flags_o         = '0;
        flags_o.busy    = (r_state != ST_IDLE);
        flags_o.done    = (r_state == ST_DONE);
        flags_o.acc_cnt = r_acc_cnt;
        flags_o.out_cnt = r_out_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_accum_engine.sv
// ============================================================================
// Module      : tb_mac_accum_engine
// Description : Self-checking bench for mac_accum_engine against a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accum_engine;
    import mac_accum_package::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clr;
    ctrl_engine_t  ctrl;
    flags_engine_t flags;

    int          errors = 0;
    int          checks = 0;
    int          a_vals[$];
    int          b_vals[$];
    logic [31:0] got_c[$];
    logic [31:0] exp_c[$];
    int          lat_first;
    int          max_out_cnt;
    int          done_cyc;
    bit          stall_bad;
    bit          stall_aready;
    bit          timed_out;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) a_s ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) b_s ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) c_s ();

    always #5 clk = ~clk;

    mac_accum_engine dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (en),
        .clear_i  (clr),
        .a_i      (a_s),
        .b_i      (b_s),
        .c_o      (c_s),
        .ctrl_i   (ctrl),
        .flags_o  (flags)
    );

    // Job-level reference: sum len signed products mod 2^64, shift, then reduce.
    function automatic logic [31:0] model_res(input int len, input int sh, input int base);
        longint acc;
        longint s;
        acc = 0;
        for (int i = 0; i < len; i++) begin
            acc += longint'(a_vals[base + i]) * longint'(b_vals[base + i]);
        end
        s = acc >>> sh;
`ifdef MAC_ACCUM_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic void build_exp(input int len, input int nb, input int sh);
        exp_c.delete();
        for (int r = 0; r < nb; r++) exp_c.push_back(model_res(len, sh, r * len));
    endfunction

    task automatic fill_random(input int n);
        a_vals.delete();
        b_vals.delete();
        for (int i = 0; i < n; i++) begin
            a_vals.push_back(int'($urandom()));
            b_vals.push_back(($urandom_range(0, 1) == 1) ? int'($urandom()) : int'($urandom_range(0, 200)) - 100);
        end
    endtask

    task automatic run_job(input int len, input int nb, input int sh, input bit b_sparse, input int stall);
        int          ai = 0;
        int          cyc = 0;
        int          stall_left = stall;
        int          last_hs = -100;
        bit          prev_cv = 1'b0;
        bit          in_stall = 1'b0;
        logic [31:0] held = '0;
        got_c.delete();
        lat_first = -1; max_out_cnt = 0; done_cyc = -1;
        stall_bad = 1'b0; stall_aready = 1'b0; timed_out = 1'b0;
        @(posedge clk); #1;
        ctrl.start = 1'b1; ctrl.len = 16'(len); ctrl.nb_out = 16'(nb); ctrl.shift = 6'(sh);
        @(posedge clk); #1;
        ctrl.start = 1'b0;
        forever begin
            a_s.valid = (ai < a_vals.size());
            b_s.valid = (ai < b_vals.size()) && (!b_sparse || (cyc % 2 == 1));
            if (ai < a_vals.size()) begin
                a_s.data = a_vals[ai];
                b_s.data = b_vals[ai];
            end
            c_s.ready = !(c_s.valid && stall_left > 0);
            @(negedge clk);
            cyc++;
            if (a_s.valid && b_s.valid && a_s.ready && b_s.ready) begin
                ai++;
                last_hs = cyc;
            end
            if (c_s.valid && !prev_cv && lat_first < 0) lat_first = cyc - last_hs;
            if (c_s.valid && !c_s.ready) begin
                if (in_stall && c_s.data !== held) stall_bad = 1'b1;
                if (a_s.ready || b_s.ready) stall_aready = 1'b1;
                held = c_s.data;
                in_stall = 1'b1;
                stall_left--;
            end else begin
                in_stall = 1'b0;
            end
            if (c_s.valid && c_s.ready) got_c.push_back(c_s.data);
            prev_cv = c_s.valid;
            if (int'(flags.out_cnt) > max_out_cnt) max_out_cnt = int'(flags.out_cnt);
            if (flags.done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        a_s.valid = 1'b0;
        b_s.valid = 1'b0;
        c_s.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; en = 1'b1; ctrl = '0;
        a_s.valid = 1'b1; b_s.valid = 1'b1; a_s.data = '0; b_s.data = '0;
        a_s.strb = '1; b_s.strb = '1; c_s.ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (flags.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", flags.busy); end
        checks++; if (flags.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", flags.done); end
        checks++; if (flags.acc_cnt !== 16'd0 || flags.out_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: got acc=%0d out=%0d expected 0/0", flags.acc_cnt, flags.out_cnt); end
        checks++; if (c_s.valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %0b expected 0", c_s.valid); end
        checks++; if (a_s.ready !== 1'b0 || b_s.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got a=%0b b=%0b expected 0/0", a_s.ready, b_s.ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_s.ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %0b expected 0", a_s.ready); end
        a_s.valid = 1'b0; b_s.valid = 1'b0; c_s.ready = 1'b0;
    endtask

    task automatic test_basic();
        a_vals = '{1, 2, 3, 4};
        b_vals = '{5, 6, 7, 8};
        run_job(4, 1, 0, 1'b0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout expected done"); end
        checks++; if (got_c.size() != 1 || got_c[0] !== 32'd70) begin errors++; $display("FAIL basic_c: got %0d results first=%0d expected 1 result 70", got_c.size(), (got_c.size() > 0) ? got_c[0] : 32'hX); end
        checks++; if (lat_first != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat_first); end
        @(posedge clk); #1;
        checks++; if (flags.done !== 1'b0 || flags.busy !== 1'b0) begin errors++; $display("FAIL basic_after_done: got done=%0b busy=%0b expected 0/0", flags.done, flags.busy); end
    endtask

    task automatic test_multi();
        a_vals = '{3, 3, 3, 3, 3, 3};
        b_vals = '{3, 3, 3, 3, 3, 3};
        run_job(2, 3, 1, 1'b0, 0);
        checks++; if (got_c.size() != 3) begin errors++; $display("FAIL multi_count: got %0d expected 3", got_c.size()); end
        foreach (got_c[i]) begin
            checks++; if (got_c[i] !== 32'd9) begin errors++; $display("FAIL multi_c%0d: got %0d expected 9", i, got_c[i]); end
        end
        checks++; if (max_out_cnt != 3) begin errors++; $display("FAIL multi_out_cnt: got %0d expected 3", max_out_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int len = int'($urandom_range(1, 5));
            int nb  = int'($urandom_range(1, 3));
            int sh  = (it == 4) ? 63 : int'($urandom_range(0, 40));
            fill_random(len * nb);
            build_exp(len, nb, sh);
            run_job(len, nb, sh, 1'b0, 0);
            checks++; if (got_c.size() != exp_c.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, got_c.size(), exp_c.size()); end
            foreach (got_c[i]) begin
                if (i < exp_c.size()) begin
                    checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL rand%0d_c%0d: got %08h expected %08h", it, i, got_c[i], exp_c[i]); end
                end
            end
        end
    endtask

    task automatic test_sparse_b();
        logic [31:0] ref_c[$];
        fill_random(10);
        build_exp(5, 2, 3);
        run_job(5, 2, 3, 1'b0, 0);
        ref_c = got_c;
        run_job(5, 2, 3, 1'b1, 0);
        checks++; if (got_c.size() != 2 || ref_c.size() != 2) begin errors++; $display("FAIL sparse_count: got %0d/%0d expected 2/2", ref_c.size(), got_c.size()); end
        for (int i = 0; i < 2 && i < got_c.size() && i < ref_c.size(); i++) begin
            checks++; if (got_c[i] !== exp_c[i] || ref_c[i] !== exp_c[i]) begin errors++; $display("FAIL sparse_c%0d: got %08h/%08h expected %08h", i, ref_c[i], got_c[i], exp_c[i]); end
        end
        checks++; if (lat_first != 3) begin errors++; $display("FAIL sparse_latency: got %0d expected 3", lat_first); end
    endtask

    task automatic test_backpressure();
        fill_random(6);
        build_exp(3, 2, 2);
        run_job(3, 2, 2, 1'b0, 10);
        checks++; if (stall_bad) begin errors++; $display("FAIL stall_data_stable: got changed expected stable"); end
        checks++; if (stall_aready) begin errors++; $display("FAIL stall_in_ready: got 1 expected 0"); end
        checks++; if (got_c.size() != 2) begin errors++; $display("FAIL stall_count: got %0d expected 2", got_c.size()); end
        for (int i = 0; i < 2 && i < got_c.size(); i++) begin
            checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL stall_c%0d: got %08h expected %08h", i, got_c[i], exp_c[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
`ifdef MAC_ACCUM_SAT_EN
        exp = 32'h7FFF_FFFF;
`else
        exp = 32'h0000_0002;
`endif
        a_vals = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        b_vals = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_job(2, 1, 0, 1'b0, 0);
        checks++; if (got_c.size() != 1 || got_c[0] !== exp) begin errors++; $display("FAIL overflow_c: got %0d results first=%08h expected %08h", got_c.size(), (got_c.size() > 0) ? got_c[0] : 32'hX, exp); end
    endtask

    task automatic test_abort(input bit use_clear);
        int  hs = 0;
        int  cyc = 0;
        bit  saw_c = 1'b0;
        @(posedge clk); #1;
        ctrl.start = 1'b1; ctrl.len = 16'd4; ctrl.nb_out = 16'd1; ctrl.shift = 6'd0;
        @(posedge clk); #1;
        ctrl.start = 1'b0;
        a_s.valid = 1'b1; b_s.valid = 1'b1; a_s.data = 32'd7; b_s.data = 32'd9;
        while (hs < 2 && cyc < 50) begin
            @(negedge clk);
            if (a_s.ready) hs++;
            cyc++;
            @(posedge clk); #1;
        end
        a_s.valid = 1'b0; b_s.valid = 1'b0;
        if (use_clear) clr = 1'b1; else rst_n = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (hs != 2) begin errors++; $display("FAIL abort%0d_pairs: got %0d expected 2", use_clear, hs); end
        checks++; if (flags.busy !== 1'b0 || flags.acc_cnt !== 16'd0) begin errors++; $display("FAIL abort%0d_flags: got busy=%0b acc=%0d expected 0/0", use_clear, flags.busy, flags.acc_cnt); end
        c_s.ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (c_s.valid) saw_c = 1'b1;
        end
        c_s.ready = 1'b0;
        checks++; if (saw_c) begin errors++; $display("FAIL abort%0d_no_c: got c valid expected none", use_clear); end
        a_vals = '{2};
        b_vals = '{3};
        run_job(1, 1, 0, 1'b0, 0);
        checks++; if (got_c.size() != 1 || got_c[0] !== 32'd6) begin errors++; $display("FAIL abort%0d_next_c: got %0d results first=%0d expected 1 result 6", use_clear, got_c.size(), (got_c.size() > 0) ? got_c[0] : 32'hX); end
    endtask

    task automatic test_zero_len();
        a_vals.delete();
        b_vals.delete();
        run_job(0, 2, 0, 1'b0, 0);
        checks++; if (done_cyc != 1 || got_c.size() != 0) begin errors++; $display("FAIL zero_len: got done_cyc=%0d results=%0d expected 1/0", done_cyc, got_c.size()); end
        a_vals = '{5, 6};
        b_vals = '{7, 8};
        run_job(2, 0, 0, 1'b0, 0);
        checks++; if (done_cyc != 1 || got_c.size() != 0) begin errors++; $display("FAIL zero_nb_out: got done_cyc=%0d results=%0d expected 1/0", done_cyc, got_c.size()); end
    endtask

    initial begin
        c_s.strb = '1;
        test_reset();
        test_basic();
        test_multi();
        test_random();
        test_sparse_b();
        test_backpressure();
        test_overflow();
        test_abort(1'b0);
        test_abort(1'b1);
        test_zero_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
